// File: rtl/conv_pkg.sv
// Shared types and constants for the conv partial-sum sequencer and its
// pipelined adder-tree helpers.
package conv_pkg;

    localparam int TREE_LATENCY = 3;
    localparam int ACC_W        = 32;
    localparam int BIAS_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_BIAS,
        ST_OUT
    } psum_state_t;

endpackage

// File: rtl/valid_delay.sv
// Single-bit shift register that lines issued beats up with the output of a
// fixed-latency pipeline.
module valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] line;

    // NOTE: the line is cleared on reset so in-flight beats are discarded,
    // and non-blocking assignments make every stage take its pre-edge neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else begin
            line[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign q = line[DEPTH-1];

endmodule

// File: rtl/conv_psum_sequencer.sv
// Steps the 9-input adder tree across the input channels of each output pixel,
// accumulates the tree totals, adds bias, applies optional ReLU, and hands off.
module conv_psum_sequencer
    import conv_pkg::*;
#(
    parameter int CH_W  = 10,
    parameter int PIX_W = 16,
    parameter int ACC_W = conv_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CH_W-1:0]          num_ch,
    input  logic [PIX_W-1:0]         num_pix,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ACC_W-1:0]  tree_total,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     busy,
    output logic                     done
);

    psum_state_t             state;
    logic [CH_W-1:0]         ch_q;
    logic [CH_W-1:0]         issued;
    logic [CH_W-1:0]         received;
    logic [CH_W-1:0]         received_nx;
    logic [PIX_W-1:0]        pix_q;
    logic [PIX_W-1:0]        pix_cnt;
    logic signed [BIAS_W-1:0] bias_q;
    logic                    relu_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] res;
    logic                    fire;
    logic                    tap;
    logic                    last_pix;

    assign in_ready    = (state == ST_ISSUE);
    assign busy        = (state != ST_IDLE);
    assign fire        = in_valid & in_ready;
    assign received_nx = received + CH_W'(tap);
    assign last_pix    = (pix_cnt == pix_q - PIX_W'(1));
    assign bias_ext    = {{(ACC_W-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};

    valid_delay #(
        .DEPTH(TREE_LATENCY)
    ) u_valid_delay (
        .clk(clk),
        .rst(rst),
        .d  (fire),
        .q  (tap)
    );

    // NOTE: res gets a default before the clamp so no path leaves it unassigned.
    always_comb begin
        res = acc + bias_ext;
        if (relu_q && res[ACC_W-1]) begin
            res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ch_q      <= CH_W'(1);
            pix_q     <= PIX_W'(1);
            bias_q    <= '0;
            relu_q    <= 1'b0;
            issued    <= '0;
            received  <= '0;
            pix_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Tree totals land independently of beat issue; later FSM clears win.
            if (tap) begin
                acc      <= acc + tree_total;
                received <= received_nx;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ch_q     <= (num_ch == '0) ? CH_W'(1) : num_ch;
                        pix_q    <= (num_pix == '0) ? PIX_W'(1) : num_pix;
                        bias_q   <= bias;
                        relu_q   <= relu_en;
                        acc      <= '0;
                        issued   <= '0;
                        received <= '0;
                        pix_cnt  <= '0;
                        state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (fire) begin
                        issued <= issued + CH_W'(1);
                        if (issued + CH_W'(1) == ch_q) begin
                            state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Leave on the edge that absorbs the final total so BIAS sees it.
                    if (tap && received_nx == ch_q) begin
                        state <= ST_BIAS;
                    end
                end

                ST_BIAS: begin
                    out_data  <= res;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_pix) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            pix_cnt  <= pix_cnt + PIX_W'(1);
                            acc      <= '0;
                            issued   <= '0;
                            received <= '0;
                            state    <= ST_ISSUE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_psum_sequencer.sv
// Self-checking bench for conv_psum_sequencer: directed vector table, reset
// abort sequence, and randomized jobs against an arithmetic reference model.
module tb_conv_psum_sequencer;

    localparam int CH_W  = 10;
    localparam int PIX_W = 16;
    localparam int ACC_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [CH_W-1:0]         num_ch;
    logic [PIX_W-1:0]        num_pix;
    logic signed [15:0]      bias;
    logic                    relu_en;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] tree_total;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;
    logic                    done;

    always #5 clk = ~clk;

    conv_psum_sequencer #(
        .CH_W (CH_W),
        .PIX_W(PIX_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_ch    (num_ch),
        .num_pix   (num_pix),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tree_total(tree_total),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Adder tree stand-in: value to present on tree_total at a given cycle.
    int sched[int];
    int tot_q[$];
    logic signed [31:0] res_q[$];
    int latf_q[$];
    int latl_q[$];

    typedef struct packed {
        int ncfg;
        int npcfg;
        int b;
        bit r;
        int gap_at;
        int gap_len;
        int stall;
        int exp0;
        int exp1;
        int lat;
    } vec_t;

    vec_t vecs [9];
    int   tots [9][4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the middle of the next cycle and present that cycle's tree output.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sched.exists(cyc)) tree_total = 32'(sched[cyc]);
        else                   tree_total = 32'($urandom);
    endtask

    // Runs one job from an IDLE cycle; records each accepted result and latency.
    task automatic run_job(input int ncfg, input int npcfg, input int b, input bit r,
                           input int gap_at, input int gap_len, input int stall0,
                           input bit rnd);
        int eff_pix;
        int eff_ch;
        int sent, first, last, gapc, guard, stall, bad_ready, bad_hold;
        logic signed [31:0] held;
        eff_ch  = (ncfg == 0) ? 1 : ncfg;
        eff_pix = (npcfg == 0) ? 1 : npcfg;

        check("idle_before_start", {busy, in_ready, out_valid}, 0);
        start    = 1'b1;
        num_ch   = ncfg[CH_W-1:0];
        num_pix  = npcfg[PIX_W-1:0];
        bias     = b[15:0];
        relu_en  = r;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        start   = 1'b0;
        num_ch  = CH_W'($urandom);
        num_pix = PIX_W'($urandom);
        bias    = 16'($urandom);
        relu_en = 1'($urandom);
        check("start_to_issue", {busy, in_ready}, 2'b11);

        for (int p = 0; p < eff_pix; p++) begin
            sent = 0; first = -1; last = 0; gapc = 0; guard = 0;
            bad_ready = 0; bad_hold = 0;
            stall = rnd ? int'($urandom_range(0, 3)) : ((p == 0) ? stall0 : 0);
            out_ready = (stall == 0);

            while (sent < eff_ch && guard < 200) begin
                guard++;
                if (!in_ready) begin
                    in_valid = 1'($urandom);
                end else if (rnd ? ($urandom_range(0, 3) == 0)
                                 : (sent == gap_at && gapc < gap_len)) begin
                    in_valid = 1'b0;
                    gapc++;
                end else begin
                    in_valid = 1'b1;
                    sched[cyc+3] = tot_q.pop_front();
                    if (first < 0) first = cyc;
                    last = cyc;
                    sent++;
                end
                tick();
            end
            in_valid = 1'b0;
            check("beats_issued", sent, eff_ch);

            guard = 0;
            while (!out_valid && guard < 100) begin
                guard++;
                if (in_ready) bad_ready++;
                in_valid = in_ready ? 1'b0 : 1'($urandom);
                tick();
            end
            in_valid = 1'b0;
            check("out_valid_timeout", out_valid, 1'b1);
            latf_q.push_back(cyc - first);
            latl_q.push_back(cyc - last);

            held = out_data;
            for (int k = 0; k < stall; k++) begin
                if (in_ready) bad_ready++;
                in_valid = 1'($urandom);
                tick();
                if (!out_valid || out_data !== held) bad_hold++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            if (in_ready) bad_ready++;
            res_q.push_back(out_data);
            tick();
            out_ready = 1'b0;
            check("out_hold_during_stall", bad_hold, 0);
            check("in_ready_low_outside_issue", bad_ready, 0);

            if (p < eff_pix - 1) begin
                check("reissue_after_accept", {in_ready, out_valid, done}, 3'b100);
            end else begin
                check("done_pulse", {done, busy, out_valid}, 3'b100);
                tick();
                check("done_one_cycle", {done, busy}, 2'b00);
            end
        end
    endtask

    task automatic clear_logs();
        tot_q.delete();
        res_q.delete();
        latf_q.delete();
        latl_q.delete();
    endtask

    initial begin
        int neff;
        int nc, np, bv, nch, npx;
        bit rr;
        logic signed [15:0] b16;
        logic signed [31:0] s, t, be;
        logic signed [31:0] exp_q[$];

        rst = 1'b1; start = 1'b0; num_ch = '0; num_pix = '0; bias = '0;
        relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tree_total = '0;

        //             ncfg npix  bias  relu gap_at gap_len stall exp0     exp1 lat
        vecs[0] = '{3,   1,    5,    1'b0, -1, 0, 0, 18,           0,  7};
        vecs[1] = '{1,   1,    20,   1'b1, -1, 0, 0, 0,            0,  5};
        vecs[2] = '{1,   1,    20,   1'b0, -1, 0, 0, -80,          0,  5};
        vecs[3] = '{4,   1,    0,    1'b0,  2, 2, 0, 10,           0, 10};
        vecs[4] = '{4,   1,    0,    1'b0, -1, 0, 0, 10,           0,  8};
        vecs[5] = '{0,   0,    -2,   1'b0, -1, 0, 0, 40,           0,  5};
        vecs[6] = '{2,   1,    0,    1'b0, -1, 0, 0, 32'h80000000, 0,  6};
        vecs[7] = '{2,   2,    3,    1'b1, -1, 0, 5, 53,          12,  6};
        vecs[8] = '{1,   1, -32768,  1'b0, -1, 0, 0, -32768,       0,  5};
        tots[0] = '{10, -4, 7, 0};
        tots[1] = '{-100, 0, 0, 0};
        tots[2] = '{-100, 0, 0, 0};
        tots[3] = '{1, 2, 3, 4};
        tots[4] = '{1, 2, 3, 4};
        tots[5] = '{42, 0, 0, 0};
        tots[6] = '{32'h7FFFFFFF, 1, 0, 0};
        tots[7] = '{100, -50, 7, 2};
        tots[8] = '{0, 0, 0, 0};

        repeat (3) tick();
        check("reset_outputs_in_reset", {in_ready, out_valid, out_data, busy, done}, 0);
        rst = 1'b0;
        tick();
        check("reset_outputs_after_release", {in_ready, out_valid, out_data, busy, done}, 0);

        for (int i = 0; i < 9; i++) begin
            clear_logs();
            neff = ((vecs[i].ncfg == 0) ? 1 : vecs[i].ncfg) * ((vecs[i].npcfg == 0) ? 1 : vecs[i].npcfg);
            for (int j = 0; j < neff; j++) tot_q.push_back(tots[i][j]);
            run_job(vecs[i].ncfg, vecs[i].npcfg, vecs[i].b, vecs[i].r,
                    vecs[i].gap_at, vecs[i].gap_len, vecs[i].stall, 1'b0);
            check($sformatf("vec%0d_data0", i), res_q[0], vecs[i].exp0);
            check($sformatf("vec%0d_latency", i), latf_q[0], vecs[i].lat);
            if (vecs[i].npcfg > 1) check($sformatf("vec%0d_data1", i), res_q[1], vecs[i].exp1);
        end

        // Abort a 3-channel pixel one cycle after its second beat, then restart
        // right away so the stale tree totals would land inside the new job.
        clear_logs();
        start = 1'b1; num_ch = CH_W'(3); num_pix = PIX_W'(1); bias = '0; relu_en = 1'b0;
        tick();
        start = 1'b0;
        check("abort_job_issuing", in_ready, 1'b1);
        in_valid = 1'b1; sched[cyc+3] = 1000;
        tick();
        in_valid = 1'b1; sched[cyc+3] = 2000;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_reset_outputs", {in_ready, out_valid, out_data, busy, done}, 0);
        tot_q.push_back(9);
        run_job(1, 1, 0, 1'b0, -1, 0, 0, 1'b0);
        check("restart_no_stale_totals", res_q[0], 9);

        for (int n = 0; n < 25; n++) begin
            clear_logs();
            exp_q.delete();
            nc  = int'($urandom_range(0, 5));
            np  = int'($urandom_range(0, 3));
            bv  = int'($urandom_range(0, 65535));
            rr  = 1'($urandom);
            nch = (nc == 0) ? 1 : nc;
            npx = (np == 0) ? 1 : np;
            b16 = bv[15:0];
            be  = b16;
            for (int p = 0; p < npx; p++) begin
                s = 0;
                for (int c = 0; c < nch; c++) begin
                    if ($urandom_range(0, 1) == 0) t = 32'($urandom);
                    else                           t = int'($urandom_range(0, 2000)) - 1000;
                    tot_q.push_back(t);
                    s = s + t;
                end
                s = s + be;
                if (rr && s < 0) s = 0;
                exp_q.push_back(s);
            end
            run_job(nc, np, bv, rr, -1, 0, 0, 1'b1);
            for (int p = 0; p < npx; p++) begin
                check($sformatf("rand%0d_pix%0d_data", n, p), res_q[p], exp_q[p]);
                check($sformatf("rand%0d_pix%0d_last_beat_to_valid", n, p), latl_q[p], 5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_psum_sequencer.md
# conv_psum_sequencer

- Sequences the 3-stage pipelined 9-input adder tree across the input channels of one VGG-16 conv output pixel.
- Per pixel: issues one tree beat per input channel, tracks each beat through the fixed tree latency, and accumulates the tree totals.
- After the last channel it adds the 16-bit bias, optionally applies ReLU, and presents the result on a valid/ready output port.
- Sits between the window/weight fetch logic (which drives the tree inputs on `in_ready`) and the output feature-map writer.

## Interface
Parameters:
- `CH_W`, 10, width of the channel count (VGG-16 max 512 channels).
- `PIX_W`, 16, width of the pixel count.
- `ACC_W`, 32, accumulator and output width; equals the tree total width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a job; sampled only in IDLE.
- `num_ch` input CH_W: input channels per pixel; latched on start; 0 is treated as 1.
- `num_pix` input PIX_W: pixels per job; latched on start; 0 is treated as 1.
- `bias` input 16 signed: latched on start.
- `relu_en` input 1: latched on start.
- `in_valid` input 1: fetch logic presents 9 products to the adder tree this cycle.
- `in_ready` output 1: the sequencer accepts a beat; a beat issues on `in_valid & in_ready`.
- `tree_total` input ACC_W signed: adder tree output.
- `out_valid` output 1: result held.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output ACC_W signed: result.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the last pixel's result is accepted.

## Operation
- States: IDLE, ISSUE, DRAIN, BIAS, OUT.
- IDLE: on `start`, latch the configuration, clear the accumulator and counters, and go to ISSUE.
- ISSUE: `in_ready`=1.
  - Each issued beat increments `issued` and shifts a 1 into a 3-deep valid delay line (TREE_LATENCY=3).
  - `in_valid` while `in_ready`=0 is ignored and not counted.
  - When `issued` reaches the effective num_ch, go to DRAIN.
- Delay line: whenever its tap is 1, `acc <= acc + tree_total` (ACC_W two's-complement, wraps, no saturation) and `received` increments. This applies in both ISSUE and DRAIN.
- DRAIN: when `received` equals the effective num_ch, go to BIAS.
- BIAS: one cycle.
  - Compute `res = acc + sign_extend(bias)`.
  - If relu_en and res<0, res=0.
  - Load `out_data`; go to OUT.
- OUT: hold `out_valid`=1 and `out_data` stable until `out_ready`.
  - On acceptance with pixels remaining: clear acc, `issued` and `received`; increment the pixel counter; go to ISSUE.
  - On acceptance of the last pixel: pulse `done`; go to IDLE.
- `start` outside IDLE is ignored.
- `rst` at any point:
  - Returns to IDLE.
  - Clears the delay line, so in-flight tree results are discarded.
  - Clears acc and all counters.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
- `start` at cycle s: ISSUE, `in_ready`=1, and `busy`=1 from s+1.
- Beat issued at cycle t: its `tree_total` is sampled at t+3.
- N back-to-back beats starting at t:
  - Last total sampled at t+N+2.
  - BIAS at t+N+3.
  - `out_valid` rises at t+N+4.
- Gaps in `in_valid` delay completion by the gap length. Totals arriving in DRAIN are still accumulated.
- `out_ready` already high when `out_valid` rises: accepted that cycle; ISSUE (`in_ready`=1) the next cycle.
- `done` pulses in the cycle after the final acceptance, coincident with `busy`=0.
- A beat issue and a total arrival in the same cycle are both processed: counter and accumulator updates are independent.

## Structure
- Package `conv_pkg`:
  - `TREE_LATENCY`=3.
  - State enum `psum_state_t`.
  - Shared widths `ACC_W`, `BIAS_W`=16.
- Sub-module `valid_delay` (DEPTH=TREE_LATENCY, sync clear on `rst`): a single-bit shift register aligning beats with the tree output. It is reusable by other pipelined datapaths.

## Test plan
- num_ch=3, num_pix=1, bias=5, relu_en=0, totals 10, -4, 7 with `out_ready`=1 → `out_data`=18 at t+7, `done` one cycle later.
- num_ch=1, totals -100, bias=20, relu_en=1 → `out_data`=0. Same stimulus with relu_en=0 → -80.
- num_ch=4 with `in_valid` low for 2 cycles mid-stream → exactly 4 totals accumulated; `out_valid` is 2 cycles later than the back-to-back case.
- num_pix=2, `out_ready` held low 5 cycles on pixel 0 → `out_data` stable; `in_ready`=0 throughout the stall; pixel 1 accumulates from a cleared acc.
- `rst` asserted one cycle after the 2nd of 3 beats → next cycle is IDLE with all outputs at reset values. Restart with num_ch=1, total=9, bias=0 → `out_data`=9, with no stale totals added.
- num_ch=0, num_pix=0 → treated as 1 beat / 1 pixel. Acc wrap: totals 0x7FFFFFFF and 1 → 0x80000000.
